// File: rtl/cpu_ctrl_pkg.sv
// Shared control types for the CPU sequencers: state encoding and widths.
package cpu_ctrl_pkg;

    localparam int RETIRED_W = 32;

    // Sequencer states; the encoding is visible on waveforms, so keep it fixed.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        UPDATE = 3'd3,
        HALTED = 3'd4,
        ERROR  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/fetch_timer.sv
// Fetch watchdog: counts cycles spent waiting for instruction memory and
// flags the last allowed cycle so the sequencer can give up on the fetch.
module fetch_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic Reset,
    input  logic run,
    input  logic clr,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear dominates; otherwise advance once per waiting cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register, cleared asynchronously with the rest of the sequencer.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expired means this is the final cycle an ack may still arrive in.
    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle PC sequencer: fetch handshake, execute hold, one-cycle PC
// write per retired instruction, halt/resume, fetch timeout, retire count.
// Handshake: imem_req is held high for the whole FETCH state; any cycle in
// FETCH where imem_ack is sampled high completes the fetch. imem_ack outside
// FETCH is ignored.
module pc_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 imem_ack,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 branch_taken,
    output logic                 imem_req,
    output logic                 PCWre,
    output logic                 PCSrc,
    output logic                 halted,
    output logic                 err,
    output logic [RETIRED_W-1:0] retired
);

    seq_state_t           state_q;
    seq_state_t           state_d;
    logic                 pcsrc_q;
    logic                 pcsrc_d;
    logic [RETIRED_W-1:0] retired_q;
    logic [RETIRED_W-1:0] retired_d;
    logic                 tmr_run;
    logic                 tmr_clr;
    logic                 tmr_expired;

    // The timer only runs while waiting in FETCH; an ack or leaving FETCH
    // rearms it so every fetch gets the full window.
    assign tmr_run = (state_q == FETCH);
    assign tmr_clr = (state_q != FETCH) || imem_ack;

    fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .Reset  (Reset),
        .run    (tmr_run),
        .clr    (tmr_clr),
        .expired(tmr_expired)
    );

    // Next-state, branch-select latch and retire counter.
    always_comb begin
        state_d   = state_q;
        pcsrc_d   = pcsrc_q;
        retired_d = retired_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d = EXEC;
                end else if (tmr_expired) begin
                    state_d = ERROR;
                end
            end
            EXEC: begin
                // Stall wins over everything decoded this cycle.
                if (!stall) begin
                    if (halt_req) begin
                        state_d = HALTED;
                    end else begin
                        state_d = UPDATE;
                        pcsrc_d = branch_taken;
                    end
                end
            end
            UPDATE: begin
                retired_d = retired_q + RETIRED_W'(1);
                state_d   = FETCH;
            end
            HALTED: begin
                // Resume steps sequentially past the halt instruction.
                if (start) begin
                    state_d = UPDATE;
                    pcsrc_d = 1'b0;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            pcsrc_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pcsrc_q   <= pcsrc_d;
            retired_q <= retired_d;
        end
    end

    // Outputs decode registered state only.
    assign imem_req = (state_q == FETCH);
    assign PCWre    = (state_q == UPDATE);
    assign PCSrc    = (state_q == UPDATE) && pcsrc_q;
    assign halted   = (state_q == HALTED);
    assign err      = (state_q == ERROR);
    assign retired  = retired_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios plus random
// traffic against a cycle-level behavioural model and a PCSrc scoreboard.
module tb_pc_seq_ctrl;

    localparam int TIMEOUT = 16;

    // Model phases (bench-private numbering).
    localparam int P_IDLE = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC = 2;
    localparam int P_UPD = 3;
    localparam int P_HALT = 4;
    localparam int P_ERR = 5;

    logic        clk;
    logic        Reset;
    logic        start;
    logic        imem_ack;
    logic        stall;
    logic        halt_req;
    logic        branch_taken;
    logic        imem_req;
    logic        PCWre;
    logic        PCSrc;
    logic        halted;
    logic        err;
    logic [31:0] retired;

    int checks;
    int errors;

    // Model state
    int          m_ph;
    int          m_age;
    logic [31:0] m_ret;
    logic [0:0]  exp_q[$];

    pc_seq_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .start       (start),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .halt_req    (halt_req),
        .branch_taken(branch_taken),
        .imem_req    (imem_req),
        .PCWre       (PCWre),
        .PCSrc       (PCSrc),
        .halted      (halted),
        .err         (err),
        .retired     (retired)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model reaction to the inputs sampled at the coming rising edge.
    task automatic model_step(input logic st, input logic ack, input logic stl,
                              input logic hreq, input logic br);
        case (m_ph)
            P_IDLE: if (st) begin m_ph = P_FETCH; m_age = 0; end
            P_FETCH: begin
                if (ack) begin
                    m_ph = P_EXEC;
                end else begin
                    m_age++;
                    if (m_age >= TIMEOUT) m_ph = P_ERR;
                end
            end
            P_EXEC: begin
                if (!stl) begin
                    if (hreq) begin
                        m_ph = P_HALT;
                    end else begin
                        m_ph = P_UPD;
                        exp_q.push_back(br);
                    end
                end
            end
            P_UPD: begin
                m_ret = m_ret + 32'd1;
                m_ph  = P_FETCH;
                m_age = 0;
            end
            P_HALT: if (st) begin m_ph = P_UPD; exp_q.push_back(1'b0); end
            default: ;
        endcase
    endtask

    // Compare every output against the model; PCWre pulses consume the scoreboard.
    task automatic compare_all();
        logic [0:0] e;
        check_eq("imem_req", 32'(imem_req), 32'(m_ph == P_FETCH));
        check_eq("pcwre", 32'(PCWre), 32'(m_ph == P_UPD));
        check_eq("halted", 32'(halted), 32'(m_ph == P_HALT));
        check_eq("err", 32'(err), 32'(m_ph == P_ERR));
        check_eq("retired", retired, m_ret);
        if (m_ph != P_UPD) check_eq("pcsrc_idle", 32'(PCSrc), 32'd0);
        if (PCWre) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_pcsrc", 32'(PCSrc), 32'(e));
            end
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then compare at the next one.
    task automatic cycle(input logic st, input logic ack, input logic stl,
                         input logic hreq, input logic br);
        start        = st;
        imem_ack     = ack;
        stall        = stl;
        halt_req     = hreq;
        branch_taken = br;
        model_step(st, ack, stl, hreq, br);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        Reset        = 1'b0;
        start        = 1'b0;
        imem_ack     = 1'b0;
        stall        = 1'b0;
        halt_req     = 1'b0;
        branch_taken = 1'b0;
        m_ph  = P_IDLE;
        m_age = 0;
        m_ret = 32'd0;
        exp_q.delete();
        @(negedge clk);
        compare_all();
        Reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        do_reset();

        // 4 back-to-back instructions, immediate ack, no stall
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        check_eq("t1_retired", retired, 32'd4);

        // Branch taken held through 3 stall cycles
        cycle(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check_eq("t2_pcsrc", 32'(PCSrc), 32'd1);
        cycle(0, 0, 0, 0, 0);

        // Halt then resume
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 1);
        check_eq("t3_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 1, 1);
        check_eq("t3_retired", retired, 32'd5);
        cycle(1, 0, 0, 0, 1);
        check_eq("t3_pcwre", 32'(PCWre), 32'd1);
        cycle(0, 0, 0, 0, 0);
        check_eq("t3_refetch", 32'(imem_req), 32'd1);

        // Retire counter wrap: preload all ones while waiting in FETCH
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFF;
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("wrap_retired", retired, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 1)));
        end

        // Async reset while in UPDATE
        do_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_eq("rst_pre_pcwre", 32'(PCWre), 32'd1);
        check_eq("rst_pre_retired", retired, 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("rst_pcwre", 32'(PCWre), 32'd0);
        check_eq("rst_pcsrc", 32'(PCSrc), 32'd0);
        check_eq("rst_retired", retired, 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        do_reset();

        // Fetch timeout with ack held low
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            check_eq("tmo_early_err", 32'(err), 32'd0);
            cycle(0, 0, 0, 0, 0);
        end
        check_eq("tmo_last_err", 32'(err), 32'd0);
        cycle(0, 0, 0, 0, 0);
        check_eq("tmo_err", 32'(err), 32'd1);
        check_eq("tmo_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 1);
        check_eq("tmo_sticky", 32'(err), 32'd1);
        check_eq("tmo_pcwre", 32'(PCWre), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Multi-cycle sequencer for the program-counter unit. It sits between the instruction-memory handshake, the decode/execute stage and the PC register. It generates the PC's `PCWre` (write enable) and `PCSrc` (branch select) so the PC advances exactly once per retired instruction. It also adds fetch handshaking, stall holding, halt/resume, a fetch timeout and a retired-instruction counter.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles in FETCH without `imem_ack` before error; legal range 2..255.

Ports:
- `clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that leaves IDLE, or resumes from HALTED.
- `imem_ack` input 1: instruction memory has the word for the current PC.
- `stall` input 1: execute stage not finished (hazard or dmem busy); hold in EXEC.
- `halt_req` input 1: decoded instruction is a halt; sampled in EXEC.
- `branch_taken` input 1: branch resolved taken; sampled in EXEC.
- `imem_req` output 1: fetch request to instruction memory.
- `PCWre` output 1: PC write enable, to the PC unit.
- `PCSrc` output 1: 1 selects PC+4+imm*4, 0 selects PC+4.
- `halted` output 1: in HALTED.
- `err` output 1: fetch timeout occurred; sticky.
- `retired` output 32: count of completed PC updates.

## Operation
States: IDLE, FETCH, EXEC, UPDATE, HALTED, ERROR.
- **IDLE:** all outputs 0; `start`=1 → FETCH.
- **FETCH:**
  - `imem_req`=1.
  - `imem_ack`=1 → EXEC; timeout counter clears.
  - Otherwise the counter increments. When it equals `TIMEOUT`-1 with no ack → ERROR.
- **EXEC:**
  - `stall`=1 → stay.
  - `stall`=0 and `halt_req`=1 → HALTED.
  - `stall`=0 and `halt_req`=0 → UPDATE, with `branch_taken` latched into the `PCSrc` register.
  - `stall` has priority over `halt_req` and `branch_taken`.
- **UPDATE:**
  - `PCWre`=1 for exactly one cycle; `PCSrc` holds the latched value.
  - `retired` += 1, wrapping 0xFFFFFFFF → 0.
  - Next state is always FETCH.
- **HALTED:**
  - `halted`=1.
  - `start`=1 → UPDATE with `PCSrc` forced to 0, so the halt instruction is stepped over.
  - All other inputs are ignored.
- **ERROR:**
  - `err`=1, `imem_req`=0, `PCWre`=0.
  - Exits only via `Reset`.

Other rules:
- `imem_ack` outside FETCH is ignored.
- `start` outside IDLE/HALTED is ignored.
- `PCSrc` is 0 in every state except UPDATE.
- All outputs are decoded from registered state and registered `PCSrc`; there is no combinational input-to-output path.

## Timing
- Reset values: state=IDLE; `imem_req`, `PCWre`, `PCSrc`, `halted`, `err` = 0; `retired` = 0; timeout counter = 0.
- `Reset` low mid-operation returns everything to reset values immediately, with no clock needed. A pending PC update is dropped.
- Best-case latency, with ack sampled at edge N:
  - EXEC during cycle N+1.
  - UPDATE (`PCWre`=1) during cycle N+2; the PC changes at the end of N+2.
  - FETCH with `imem_req`=1 again from cycle N+3.
- Steady-state throughput: 3 cycles per instruction with immediate ack and no stall.
- Each stall cycle adds 1 cycle.
- Timeout: `err` rises exactly `TIMEOUT` cycles after entering FETCH with ack held low.
- `start` sampled in IDLE → `imem_req`=1 on the next cycle.

## Structure
- Shared package `cpu_ctrl_pkg`: state enum `seq_state_t` (IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALTED=4, ERROR=5) and the `RETIRED_W`=32 constant.
- One sub-module, `fetch_timer`:
  - Parameterised on `TIMEOUT`.
  - Inputs: `clk`, `Reset`, `run`, `clr`.
  - Output: `expired`.
  - Counter width $clog2(`TIMEOUT`).
- FSM, `PCSrc` latch and retired counter live in `pc_seq_ctrl`.

## Test plan
- Reset, `start`, ack every FETCH, no stall, 4 instructions → `PCWre` pulses every 3rd cycle, `retired`=4, `PCSrc`=0 on each pulse.
- Ack, then `branch_taken`=1 with `stall`=1 for 3 cycles, then `stall`=0 → stays in EXEC 4 cycles, one `PCWre` pulse with `PCSrc`=1.
- `halt_req`=1 in EXEC → `halted`=1, no `PCWre`, `retired` unchanged; `start` → one `PCWre` with `PCSrc`=0, then FETCH.
- `TIMEOUT`=16, ack held low → `err`=1 exactly 16 cycles after FETCH entry; `imem_req`=0; a later `start` or `imem_ack` has no effect.
- `Reset` asserted while in UPDATE (between edges) → `PCWre`=0 and state=IDLE immediately, `retired`=0.
- `retired` preloaded near wrap via 2^32 updates (or a forced value 0xFFFFFFFF) → next UPDATE gives `retired`=0.
